inv_result_reader: RTL and testbench
====================================

// Module: inv_result_reader
// PURPOSE
//  Read-out end of the matrixInversion datapath. Watches the final step strobe (cnt40).
//  On its rising edge, snapshots detA and the 25 ansRC words into a local bank.
//  Then streams them one word per handshake over a valid/ready port: detA first, then ans00..ans44 row-major.
//  Lets downstream logic or a host read results without 26 parallel 64-bit buses.
// PARAMETERS
//  DATA_W   64  width of every result word (detA, ansRC)
//  N        5   matrix order; stream length = N*N+1 words
//  IDX_W    5   width of out_index; must be >= clog2(N*N+1)
// PORTS
//  clk        in   1            rising-edge clock, same as matrixInversion
//  rst_n      in   1            asynchronous active-low reset
//  cnt40      in   1            final-step strobe, a level held high once inversion completes
//  detA       in   DATA_W       determinant from matrixInversion
//  ans_flat   in   N*N*DATA_W   ansRC packed; word k=R*N+C at bits [k*DATA_W +: DATA_W]
//  out_data   out  DATA_W       current stream word
//  out_valid  out  1            out_data is valid
//  out_ready  in   1            sink accepts the word when out_valid & out_ready at a clk edge
//  out_last   out  1            high with the final word of a frame
//  out_index  out  IDX_W        0 = detA, k+1 = ans word k
//  busy       out  1            high in STREAM
//  done       out  1            one-cycle pulse after the last word is accepted
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, state IDLE, cnt40 edge register 0, bank contents don't-care.
//  Edge detect: trig = cnt40 & ~cnt40_q; cnt40_q is registered every cycle.
//   A level that is already high when reset is released is NOT a trigger.
//  FSM states: IDLE, STREAM, DONE.
//   IDLE   -> STREAM on trig. At that same edge:
//            - bank[0] <= detA; bank[1..N*N] <= ans_flat
//            - index <= 0; out_valid <= 1
//   STREAM:
//            - out_data = bank[index] (registered mux); out_index = index
//            - out_last = (index == N*N)
//            - handshake and index < N*N: index <= index+1; out_valid stays 1 (back-to-back, 1 word/cycle)
//            - handshake and out_last: out_valid <= 0, out_last <= 0, go to DONE
//            - no handshake: out_data, out_index, out_last held stable (no retraction, no change)
//   DONE   -> IDLE after one cycle; done = 1 only in that cycle.
//  Latency: the first word is valid on the cycle after the trig edge.
//   With out_ready tied high: 26 words in 26 cycles, done on cycle 27.
//  trig while in STREAM or DONE: ignored. Inputs are not resampled; the frame in progress completes unchanged.
//   A later rearm needs cnt40 to fall and rise again.
//  Inputs detA and ans_flat are sampled only at the trig edge.
//   Changes after that edge do not affect the frame in progress.
//  Reset mid-frame: out_valid drops immediately (async); no done pulse; the frame is lost.
//  busy = (state == STREAM).
//  out_data is a registered copy, not a combinational path from the inputs.
// CONFIGURATION
//  SINGULAR_SKIP_EN defined:
//   - if detA == 0 at the trig edge, the frame is the detA word only
//     (index 0, out_last=1, ans words not emitted)
//   - extra output port singular (1 bit) is set with that word and held until the next trig or reset
//  SINGULAR_SKIP_EN undefined:
//   - all N*N+1 words are always streamed, regardless of detA
//   - no singular port
// TESTING
//  1. cnt40 0->1, detA=64'd42, ansRC = 16*R+C, out_ready=1:
//     26 words 42,0x00,0x01..0x44, out_index 0..25, out_last on index 25, done one cycle after.
//  2. Same stimulus, out_ready toggling 1,0,0,1,...:
//     no word lost or duplicated; out_data/out_index stable while out_valid=1 and out_ready=0.
//  3. Second cnt40 rising edge while streaming at index 10:
//     frame continues 11..25 with the original data; then return to IDLE with no new frame.
//     After cnt40 0->1 again, a new frame starts.
//  4. Power up with cnt40=1 and release rst_n: no frame. Assert rst_n=0 at index 7:
//     out_valid=0 immediately, done never pulses, IDLE after release.
//  5. SINGULAR_SKIP_EN defined, detA=0: single word 0 with out_last=1, singular=1, done next cycle.
//     Repeat with detA=5: full 26-word frame, singular=0.

Source files
------------

// File: rtl/inv_result_reader.sv
// Read-out end of the matrixInversion datapath: on a cnt40 rising edge, snapshot detA and ansRC, then stream them over valid/ready.
// Optional feature macro SINGULAR_SKIP_EN: when detA == 0 at the trigger, emit only the detA word and raise `singular`.
`timescale 1ns/1ps
module inv_result_reader #(
  parameter int DATA_W = 64,
  parameter int N      = 5,
  parameter int IDX_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cnt40,
  input  logic [DATA_W-1:0]     detA,
  input  logic [N*N*DATA_W-1:0] ans_flat,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [IDX_W-1:0]      out_index,
  output logic                  busy,
  output logic                  done
`ifdef SINGULAR_SKIP_EN
  ,
  output logic                  singular
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_e;

  localparam int unsigned       WORDS    = N * N + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N * N);

  state_e            state_q, state_d;
  logic              cnt40_q;
  logic              armed_q;
  logic [IDX_W-1:0]  index_q, index_d, next_idx;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] bank_q [WORDS];
  logic              trig, load, hs, is_last;

  // armed_q stays low until cnt40 has been seen low after reset, so a level
  // that is already high at reset release cannot look like a rising edge.
  assign trig     = cnt40 & ~cnt40_q & armed_q;
  assign load     = (state_q == S_IDLE) & trig;
  assign hs       = (state_q == S_STREAM) & out_ready;
  assign next_idx = index_q + 1'b1;

`ifdef SINGULAR_SKIP_EN
  logic singular_q, singular_d;
  assign is_last = (index_q == LAST_IDX) | singular_q;
`else
  assign is_last = (index_q == LAST_IDX);
`endif

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values and updates together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt40_q <= 1'b0;
      armed_q <= 1'b0;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt40_q <= cnt40;
      armed_q <= armed_q | ~cnt40;
      index_q <= index_d;
      data_q  <= data_d;
    end
  end

`ifdef SINGULAR_SKIP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) singular_q <= 1'b0;
    else        singular_q <= singular_d;
  end
`endif

  // NOTE: the bank is plain storage fully rewritten on every load, so it has no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      bank_q[0] <= detA;
      for (int k = 0; k < N * N; k++) begin
        bank_q[k+1] <= ans_flat[k*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    data_d  = data_q;
`ifdef SINGULAR_SKIP_EN
    singular_d = singular_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_STREAM;
          index_d = '0;
          // The bank is being written on this same edge, so take detA straight from the port.
          data_d  = detA;
`ifdef SINGULAR_SKIP_EN
          singular_d = (detA == '0);
`endif
        end
      end
      S_STREAM: begin
        if (hs) begin
          if (is_last) begin
            state_d = S_DONE;
          end else begin
            index_d = next_idx;
            data_d  = bank_q[next_idx];
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == S_STREAM);
    out_last  = (state_q == S_STREAM) & is_last;
    out_data  = data_q;
    out_index = index_q;
    busy      = (state_q == S_STREAM);
    done      = (state_q == S_DONE);
`ifdef SINGULAR_SKIP_EN
    singular  = singular_q;
`endif
  end

endmodule

// File: tb/tb_inv_result_reader.sv
// Scoreboard bench for inv_result_reader: expected words are queued when a frame is triggered and popped on each handshake.
// Build with SINGULAR_SKIP_EN defined to also cover the singular-skip variant.
`timescale 1ns/1ps
module tb_inv_result_reader;

  localparam int DATA_W = 64;
  localparam int N      = 5;
  localparam int IDX_W  = 5;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              last;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n, cnt40, out_ready;
  logic [DATA_W-1:0]     detA;
  logic [N*N*DATA_W-1:0] ans_flat;
  logic [DATA_W-1:0]     out_data;
  logic                  out_valid, out_last, busy, done;
  logic [IDX_W-1:0]      out_index;
`ifdef SINGULAR_SKIP_EN
  logic                  singular;
`endif

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  inv_result_reader #(.DATA_W(DATA_W), .N(N), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .cnt40(cnt40), .detA(detA), .ans_flat(ans_flat),
`ifdef SINGULAR_SKIP_EN
    .singular(singular),
`endif
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_index(out_index), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Load detA and ansRC = 16*R+C, queue the expected frame, and raise cnt40 at a falling edge.
  task automatic load_frame(input logic [DATA_W-1:0] d, input bit skip);
    exp_t e;
    @(negedge clk);
    detA = d;
    for (int k = 0; k < N * N; k++) ans_flat[k*DATA_W +: DATA_W] = DATA_W'(16 * (k / N) + (k % N));
    e.data = d; e.idx = '0; e.last = skip;
    sb.push_back(e);
    if (!skip) begin
      for (int k = 0; k < N * N; k++) begin
        e.data = DATA_W'(16 * (k / N) + (k % N));
        e.idx  = IDX_W'(k + 1);
        e.last = (k == N * N - 1);
        sb.push_back(e);
      end
    end
    cnt40 = 1'b1;
  endtask

  task automatic idle_gap();
    @(negedge clk);
    cnt40 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // mode 0: ready always high; mode 1: ready 1,0,0 repeating.
  // retrig_at: re-raise cnt40 and scramble inputs when this index is shown.
  // abort_at: assert reset when this index is shown.
  task automatic run_stream(input int mode, input int retrig_at, input int abort_at, output int cyc);
    bit retrigged = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc > 200) begin
        n_cmp++; n_err++;
        $display("FAIL stream_timeout: %0d words still outstanding, expected 0", sb.size());
        sb.delete();
        out_ready = 1'b0;
        return;
      end
      if (retrig_at >= 0 && cyc == 1) cnt40 = 1'b0;
      out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 1);
      if (out_valid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL extra_word: got idx %0d data %h, expected no word", out_index, out_data);
        end else if ({out_data, out_index, out_last} !== {sb[0].data, sb[0].idx, sb[0].last}) begin
          n_err++;
          $display("FAIL word: got idx %0d data %h last %b, expected idx %0d data %h last %b",
                   out_index, out_data, out_last, sb[0].idx, sb[0].data, sb[0].last);
        end
        if (abort_at >= 0 && int'(out_index) == abort_at) begin
          rst_n = 1'b0;
          #1;
          n_cmp++;
          if ({out_valid, busy, out_last, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL async_reset: got valid/busy/last/done %b, expected 0000",
                     {out_valid, busy, out_last, done});
          end
          sb.delete();
          out_ready = 1'b0;
          return;
        end
        if (retrig_at >= 0 && !retrigged && int'(out_index) == retrig_at) begin
          cnt40     = 1'b1;
          detA      = '1;
          ans_flat  = ~ans_flat;
          retrigged = 1'b1;
        end
        if (out_ready && sb.size() > 0) begin
          void'(sb.pop_front());
          if (sb.size() == 0) begin
            @(negedge clk);
            cyc++;
            out_ready = 1'b0;
            n_cmp++;
            if ({done, out_valid, busy} !== 3'b100) begin
              n_err++;
              $display("FAIL done_pulse: got done/valid/busy %b, expected 100", {done, out_valid, busy});
            end
            @(negedge clk);
            n_cmp++;
            if ({done, out_valid, busy} !== 3'b000) begin
              n_err++;
              $display("FAIL back_to_idle: got done/valid/busy %b, expected 000", {done, out_valid, busy});
            end
            return;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cnt40 = 1'b0; out_ready = 1'b0; detA = '0; ans_flat = '0;
    #12;
    n_cmp++;
    if ({out_data, out_index, out_valid, out_last, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got data %h idx %0d v/l/b/d %b, expected all 0",
               out_data, out_index, {out_valid, out_last, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL idle_after_reset: got out_valid %b, expected 0", out_valid);
      end
    end
  endtask

  task automatic test_stream();
    int cyc;
    load_frame(64'd42, 1'b0);
    run_stream(0, -1, -1, cyc);
    n_cmp++;
    if (cyc !== 27) begin
      n_err++;
      $display("FAIL stream_latency: got done on cycle %0d, expected 27", cyc);
    end
    idle_gap();
  endtask

  task automatic test_backpressure();
    int cyc;
    load_frame(64'd42, 1'b0);
    run_stream(1, -1, -1, cyc);
    n_cmp++;
    if (cyc !== 77) begin
      n_err++;
      $display("FAIL stall_latency: got done on cycle %0d, expected 77", cyc);
    end
    idle_gap();
  endtask

  task automatic test_retrigger();
    int cyc;
    load_frame(64'd42, 1'b0);
    run_stream(0, 10, -1, cyc);
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, busy} !== 2'b00) begin
        n_err++;
        $display("FAIL no_rearm: got valid/busy %b with cnt40 held high, expected 00", {out_valid, busy});
      end
    end
    idle_gap();
    load_frame(64'd99, 1'b0);
    run_stream(0, -1, -1, cyc);
    idle_gap();
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    @(negedge clk);
    rst_n = 1'b0;
    cnt40 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, busy} !== 2'b00) begin
        n_err++;
        $display("FAIL high_at_release: got valid/busy %b, expected 00", {out_valid, busy});
      end
    end
    idle_gap();
    load_frame(64'd42, 1'b0);
    run_stream(0, -1, 7, cyc);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, busy, done} !== 3'b000) begin
        n_err++;
        $display("FAIL after_abort: got valid/busy/done %b, expected 000", {out_valid, busy, done});
      end
    end
    idle_gap();
  endtask

  task automatic test_zero_det();
    int cyc;
`ifdef SINGULAR_SKIP_EN
    load_frame(64'd0, 1'b1);
    run_stream(0, -1, -1, cyc);
    n_cmp++;
    if (singular !== 1'b1) begin
      n_err++;
      $display("FAIL singular_set: got %b, expected 1", singular);
    end
    idle_gap();
    load_frame(64'd5, 1'b0);
    run_stream(0, -1, -1, cyc);
    n_cmp++;
    if (singular !== 1'b0) begin
      n_err++;
      $display("FAIL singular_clear: got %b, expected 0", singular);
    end
`else
    load_frame(64'd0, 1'b0);
    run_stream(0, -1, -1, cyc);
    n_cmp++;
    if (cyc !== 27) begin
      n_err++;
      $display("FAIL zero_det_full_frame: got done on cycle %0d, expected 27", cyc);
    end
`endif
    idle_gap();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_retrigger();
    test_reset_mid_frame();
    test_zero_det();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
